// File: rtl/regfile_sb_pkg.sv
// Shared types and build defaults for regfile_sb. `DATA_WIDTH and `REGADDR_WIDTH are
// taken from globalVariables.v when that is compiled first; otherwise they fall back here.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REGADDR_WIDTH
`define REGADDR_WIDTH 5
`endif

package regfile_sb_pkg;

    typedef enum logic {
        REG_FREE = 1'b0,
        REG_BUSY = 1'b1
    } reg_state_e;

    localparam int DEF_DATA_WIDTH = `DATA_WIDTH;
    localparam int DEF_NUM_REGS   = 1 << `REGADDR_WIDTH;
    localparam int DEF_NUM_RD     = 2;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy scoreboard: owns the busy vector, the reserve handshake and busy_count.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   REG_FREE | value in the register file is current; may be reserved
//   REG_BUSY | reserved by decode, writeback outstanding; reads must stall
module reg_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rsv_valid,
    input  logic [ADDR_WIDTH-1:0] rsv_sel,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_sel,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  rsv_ready,
    output logic [ADDR_WIDTH:0]   busy_count
);

    // Register 0 has no state at all, so it can never read as busy.
    reg_state_e state [1:NUM_REGS-1];
    logic       set_busy;
    logic       clr_busy;

    always_comb begin
        busy    = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            busy[i] = (state[i] == REG_BUSY);
        end
    end

    assign rsv_ready = rsv_valid & ((rsv_sel == '0) | ~busy[rsv_sel] |
                                    (wb_en & (wb_sel == rsv_sel)));

    // A reserve of a register that is busy can only be accepted alongside its own
    // writeback, so set and clear then cancel and the count stays put.
    assign set_busy = rsv_ready & (rsv_sel != '0);
    assign clr_busy = wb_en & (wb_sel != '0) & busy[wb_sel];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                state[i] <= REG_FREE;
            end
            busy_count <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (set_busy && rsv_sel == ADDR_WIDTH'(i)) begin
                    state[i] <= REG_BUSY;
                end else if (wb_en && wb_sel == ADDR_WIDTH'(i)) begin
                    state[i] <= REG_FREE;
                end
            end
            busy_count <= busy_count + (ADDR_WIDTH+1)'(set_busy) - (ADDR_WIDTH+1)'(clr_busy);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with busy scoreboard. Define REGFILE_WB_BYPASS_EN to forward the
// writeback value and a cleared busy flag to matching read ports in the same cycle.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int NUM_RD     = DEF_NUM_RD
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_sel,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         rsv_valid,
    input  logic [ADDR_WIDTH-1:0]        rsv_sel,
    output logic                         rsv_ready,
    input  logic                         wb_en,
    input  logic [ADDR_WIDTH-1:0]        wb_sel,
    input  logic [DATA_WIDTH-1:0]        wb_data,
    output logic [ADDR_WIDTH:0]          busy_count
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [ADDR_WIDTH-1:0] sel  [NUM_RD];

    reg_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .rsv_valid  (rsv_valid),
        .rsv_sel    (rsv_sel),
        .wb_en      (wb_en),
        .wb_sel     (wb_sel),
        .busy       (busy),
        .rsv_ready  (rsv_ready),
        .busy_count (busy_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_sel != '0) begin
            regs[wb_sel] <= wb_data;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_sel
        assign sel[g] = rd_sel[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (sel[i] != '0) begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = regs[sel[i]];
                rd_busy[i]                          = busy[sel[i]];
            end
`ifdef REGFILE_WB_BYPASS_EN
            if (wb_en && sel[i] != '0 && sel[i] == wb_sel) begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wb_data;
                rd_busy[i]                          = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized bench for regfile_sb against an array-level model of the register file.
module tb_regfile_sb;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic [NRD*AW-1:0] rd_sel   = '0;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic             rsv_valid = 1'b0;
    logic [AW-1:0]    rsv_sel   = '0;
    logic             rsv_ready;
    logic             wb_en     = 1'b0;
    logic [AW-1:0]    wb_sel    = '0;
    logic [DW-1:0]    wb_data   = '0;
    logic [AW:0]      busy_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] mreg  [NR];
    bit            mbusy [NR];

    always #5 clk = ~clk;

    regfile_sb #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .ADDR_WIDTH (AW),
        .NUM_RD     (NRD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .rsv_valid  (rsv_valid),
        .rsv_sel    (rsv_sel),
        .rsv_ready  (rsv_ready),
        .wb_en      (wb_en),
        .wb_sel     (wb_sel),
        .wb_data    (wb_data),
        .busy_count (busy_count)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit m_ready();
        return rsv_valid && (rsv_sel == 0 || !mbusy[rsv_sel] || (wb_en && wb_sel == rsv_sel));
    endfunction

    function automatic int m_count();
        int n = 0;
        foreach (mbusy[i]) n += int'(mbusy[i]);
        return n;
    endfunction

    // Model: registers and busy flags as plain arrays; reserve applied after writeback so it wins.
    always @(posedge clk) begin
        bit take;
        take = m_ready();
        if (!reset) begin
            foreach (mreg[i]) begin
                mreg[i]  = '0;
                mbusy[i] = 1'b0;
            end
        end else begin
            if (wb_en && wb_sel != 0) begin
                mreg[wb_sel]  = wb_data;
                mbusy[wb_sel] = 1'b0;
            end
            if (take && rsv_sel != 0) mbusy[rsv_sel] = 1'b1;
        end
    end

    task automatic check_cycle();
        logic [AW-1:0] idx;
        logic [DW-1:0] ed;
        logic          eb;
        chk("rsv_ready", rsv_ready, m_ready());
        chk("busy_count", busy_count, m_count());
        for (int p = 0; p < NRD; p++) begin
            idx = rd_sel[p*AW +: AW];
            ed  = (idx == 0) ? '0 : mreg[idx];
            eb  = (idx == 0) ? 1'b0 : mbusy[idx];
            if (BYP && wb_en && idx != 0 && idx == wb_sel) begin
                ed = wb_data;
                eb = 1'b0;
            end
            chk($sformatf("rd_data%0d", p), rd_data[p*DW +: DW], ed);
            chk($sformatf("rd_busy%0d", p), rd_busy[p], eb);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) check_cycle();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rsv_valid = 1'b0;
        wb_en     = 1'b0;
    endtask

    function automatic logic [AW-1:0] rnd_sel();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR-1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        // reset held for two edges
        tick();
        tick();
        reset  = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < NR; i++) begin
            rd_sel = {AW'(NR-1-i), AW'(i)};
            @(negedge clk);
            chk("lit_rst_data0", rd_data[DW-1:0], 0);
            chk("lit_rst_data1", rd_data[2*DW-1:DW], 0);
            chk("lit_rst_busy", rd_busy, 0);
            chk("lit_rst_count", busy_count, 0);
            tick();
        end

        wb_en = 1'b1; wb_sel = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        idle();
        rd_sel = {5'd0, 5'd5};
        @(negedge clk);
        chk("lit_wr5", rd_data[DW-1:0], 32'hDEADBEEF);
        tick();

        wb_en = 1'b1; wb_sel = 5'd0; wb_data = 32'h1234;
        tick();
        idle();
        rd_sel = {5'd0, 5'd0};
        @(negedge clk);
        chk("lit_wr0", rd_data[DW-1:0], 0);
        tick();

        rsv_valid = 1'b1; rsv_sel = 5'd7;
        @(negedge clk);
        chk("lit_rsv7_ready", rsv_ready, 1);
        tick();
        rd_sel = {5'd0, 5'd7};
        @(negedge clk);
        chk("lit_rsv7_busy", rd_busy[0], 1);
        chk("lit_rsv7_count", busy_count, 1);
        chk("lit_rsv7_waw", rsv_ready, 0);
        tick();
        rsv_valid = 1'b0;
        wb_en = 1'b1; wb_sel = 5'd7; wb_data = 32'h55;
        tick();
        idle();
        @(negedge clk);
        chk("lit_wb7_busy", rd_busy[0], 0);
        chk("lit_wb7_count", busy_count, 0);
        chk("lit_wb7_data", rd_data[DW-1:0], 32'h55);
        tick();

        rsv_valid = 1'b1; rsv_sel = 5'd9;
        tick();
        wb_en = 1'b1; wb_sel = 5'd9; wb_data = 32'hA5;
        @(negedge clk);
        chk("lit_sim9_ready", rsv_ready, 1);
        tick();
        idle();
        rd_sel = {5'd0, 5'd9};
        @(negedge clk);
        chk("lit_sim9_data", rd_data[DW-1:0], 32'hA5);
        chk("lit_sim9_busy", rd_busy[0], 1);
        chk("lit_sim9_count", busy_count, 1);
        wb_en = 1'b1; wb_sel = 5'd9; wb_data = 32'hA5;
        tick();
        idle();

        rsv_valid = 1'b1; rsv_sel = 5'd3;
        tick();
        rsv_sel = 5'd4;
        tick();
        rsv_sel = 5'd6;
        tick();
        idle();
        @(negedge clk);
        chk("lit_three_count", busy_count, 3);
        reset = 1'b0;
        wb_en = 1'b1; wb_sel = 5'd4; wb_data = 32'hFFFF;
        tick();
        reset = 1'b1;
        idle();
        rd_sel = {5'd3, 5'd4};
        @(negedge clk);
        chk("lit_mid_rst_count", busy_count, 0);
        chk("lit_mid_rst_data4", rd_data[DW-1:0], 0);
        chk("lit_mid_rst_busy", rd_busy, 0);
        tick();

        wb_en = 1'b1; wb_sel = 5'd12; wb_data = 32'h11;
        tick();
        idle();
        rsv_valid = 1'b1; rsv_sel = 5'd12;
        tick();
        idle();
        wb_en = 1'b1; wb_sel = 5'd12; wb_data = 32'h77;
        rd_sel = {5'd12, 5'd0};
        @(negedge clk);
        chk("lit_byp_data", rd_data[2*DW-1:DW], BYP ? 32'h77 : 32'h11);
        chk("lit_byp_busy", rd_busy[1], BYP ? 1'b0 : 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("lit_after_byp_data", rd_data[2*DW-1:DW], 32'h77);
        chk("lit_after_byp_busy", rd_busy[1], 0);
        tick();

        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 299) != 0);
            rd_sel    = {rnd_sel(), rnd_sel()};
            rsv_valid = ($urandom_range(0, 1) == 1);
            rsv_sel   = rnd_sel();
            wb_en     = ($urandom_range(0, 2) != 0);
            wb_sel    = rnd_sel();
            wb_data   = $urandom;
            tick();
        end

        idle();
        reset = 1'b1;
        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the integer register file: configurable data width, register count and read-port count.
- Adds a per-register busy scoreboard with a reserve/writeback handshake, so the decode stage can stall on RAW and WAW hazards.
- Sits between decode (read ports, reserve) and writeback (write port, clears busy).
- Register 0 is hardwired to zero and is never busy.

Parameters:
- DATA_WIDTH, 32, bits per register.
- NUM_REGS, 32, architectural register count; must be a power of 2 and ≥ 2.
- ADDR_WIDTH, $clog2(NUM_REGS), register index width.
- NUM_RD, 2, number of read ports, 1..4.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge; 0 = reset.
- rd_sel  in  NUM_RD*ADDR_WIDTH  packed read indices; port i is bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data, combinational.
- rd_busy  out  NUM_RD  busy flag of each selected register, combinational.
- rsv_valid  in  1  decode requests to reserve destination rsv_sel.
- rsv_sel  in  ADDR_WIDTH  destination to reserve.
- rsv_ready  out  1  reservation accepted this cycle, combinational.
- wb_en  in  1  writeback strobe.
- wb_sel  in  ADDR_WIDTH  writeback destination.
- wb_data  in  DATA_WIDTH  writeback value.
- busy_count  out  ADDR_WIDTH+1  registered count of busy registers.

Behaviour:
- Reset (reset=0 at a clk edge): every register = 0, every busy bit = 0, busy_count = 0. An in-flight reservation is dropped. A wb_en in the same cycle is ignored.
- Read: rd_data[i] = reg[rd_sel[i]]. Index 0 always returns 0. Read latency is 0 cycles (combinational).
- rd_busy[i] = busy[rd_sel[i]]; always 0 for index 0.
- Write: on the clk edge with wb_en=1 and wb_sel≠0, reg[wb_sel] <= wb_data and busy[wb_sel] <= 0. A write to index 0 is discarded.
- A writeback to a non-busy register is legal: data is written, busy stays 0.
- rsv_ready = rsv_valid & (rsv_sel==0 | ~busy[rsv_sel] | (wb_en & wb_sel==rsv_sel)). A register being written back this cycle may be re-reserved in the same cycle.
- Reserve handshake: when rsv_valid & rsv_ready and rsv_sel≠0, busy[rsv_sel] <= 1 at the clk edge.
- Reserving index 0 is accepted with no state change.
- When rsv_valid=1 and rsv_ready=0 (WAW stall), nothing changes. Decode must hold rsv_valid and rsv_sel stable until rsv_ready=1.
- Same register reserved and written back in one cycle: the reserve wins. Data is written and busy ends at 1.
- busy_count <= busy_count + set − clear, where set and clear are each 0 or 1 for the cycle. A simultaneous set and clear on the same register is net 0. busy_count never exceeds NUM_REGS−1.
- State machine per register: FREE –reserve→ BUSY; BUSY –writeback→ FREE; BUSY –writeback+reserve→ BUSY; any state –reset→ FREE.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: when wb_en=1 and rd_sel[i]==wb_sel≠0, rd_data[i] = wb_data and rd_busy[i] = 0 in the same cycle (write-to-read forwarding).
- Undefined: rd_data shows the old value and rd_busy shows the pre-edge busy bit until the next cycle. Decode must stall one extra cycle.

Decomposition:
- DATA_WIDTH and REGADDR_WIDTH defaults stay in globalVariables.v as `DATA_WIDTH and `REGADDR_WIDTH; the module parameters default to these defines.
- The storage array, read mux and write decode live in regfile_sb.
- Sub-module reg_scoreboard owns the busy vector, rsv_ready and busy_count.
  - Inputs: rsv_valid, rsv_sel, wb_en, wb_sel.
  - Outputs: the busy vector, rsv_ready, busy_count.

Test Plan:
- Reset then read: hold reset=0 for 2 cycles, then read all indices → rd_data=0, rd_busy=0, busy_count=0.
- Write/read: wb_en=1, wb_sel=5, wb_data=0xDEADBEEF → next cycle rd_sel[0]=5 gives 0xDEADBEEF. A write of 0x1234 to index 0 → reads 0.
- Reserve and RAW: reserve 7 (rsv_ready=1) → rd_busy=1 for index 7 and busy_count=1. Reserve 7 again → rsv_ready=0. Writeback 7 with 0x55 → busy clears, busy_count=0, and the read returns 0x55.
- Simultaneous events: with 9 busy, assert reserve 9 and writeback 9 (0xA5) in one cycle → rsv_ready=1, reg9=0xA5, busy[9]=1, busy_count unchanged.
- Reset mid-operation: reserve 3, 4 and 6 → busy_count=3. Assert reset=0 together with wb_en to index 4 → all busy bits 0, reg4=0, busy_count=0.
- Bypass, with REGFILE_WB_BYPASS_EN defined: wb to 12 with 0x77 while rd_sel[1]=12 → rd_data[1]=0x77 and rd_busy[1]=0 in the same cycle. Undefined: the old value is returned in that cycle.
